// File: rtl/memory_port_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one memory port, one transaction in flight.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on conflicts instead of fixed data priority.
module memory_port_arbiter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_resp_valid,
    output logic [31:0]       if_resp_data,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [XLEN-1:0]   d_req_wdata,
    input  logic [3:0]        d_req_write_en,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [XLEN-1:0]   d_resp_data,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [3:0]        mem_req_write_en,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   grant_data;
    logic   grant_fetch;
    logic   owner_data;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data was granted last; reset to "fetch last" so the first conflict goes to data
    logic last_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_data <= 1'b0;
        end else if (grant_data || grant_fetch) begin
            last_data <= grant_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the IDLE-cycle grant decision
    always_comb begin
        state_next  = state;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        case (state)
            IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (d_req_valid && if_req_valid) begin
                    grant_data  = !last_data;
                    grant_fetch = last_data;
                end else begin
                    grant_data  = d_req_valid;
                    grant_fetch = if_req_valid;
                end
`else
                grant_data  = d_req_valid;
                grant_fetch = if_req_valid && !d_req_valid;
`endif
                if (d_req_valid || if_req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if_req_ready  = grant_fetch;
        d_req_ready   = grant_data;
        mem_req_valid = (state == ISSUE);
    end

    // Request latch and response routing
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_data       <= 1'b0;
            mem_req_addr     <= '0;
            mem_req_wdata    <= '0;
            mem_req_write_en <= 4'b0000;
            if_resp_valid    <= 1'b0;
            if_resp_data     <= 32'h0;
            d_resp_valid     <= 1'b0;
            d_resp_data      <= '0;
        end else begin
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
            if (grant_data) begin
                owner_data       <= 1'b1;
                mem_req_addr     <= d_req_addr;
                mem_req_wdata    <= d_req_wdata;
                mem_req_write_en <= d_req_write_en;
            end else if (grant_fetch) begin
                owner_data       <= 1'b0;
                mem_req_addr     <= if_req_addr;
                mem_req_wdata    <= '0;
                mem_req_write_en <= 4'b0000;
            end
            if (state == WAIT && mem_resp_valid) begin
                if (owner_data) begin
                    d_resp_valid <= 1'b1;
                    d_resp_data  <= (mem_req_write_en == 4'b0000) ? mem_resp_data : '0;
                end else begin
                    if_resp_valid <= 1'b1;
                    if_resp_data  <= mem_resp_data[31:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: expected requests/responses queued by the test body,
// checked by a memory responder and a response monitor.
module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_req_addr, if_resp_data;
    logic        d_req_valid, d_req_ready, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [3:0]  d_req_write_en;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [3:0]  mem_req_write_en;

    memory_port_arbiter #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_req_write_en(d_req_write_en), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_write_en(mem_req_write_en), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } req_t;

    typedef struct {
        bit          is_data;
        logic [31:0] data;
    } resp_t;

    req_t        exp_req[$];
    resp_t       exp_resp[$];
    logic [31:0] if_q[$];
    req_t        d_q[$];

    int checks = 0;
    int errors = 0;
    bit auto_mem = 1'b1;
    int ready_delay = 0;
    bit stray = 1'b0;
    bit if_acc = 1'b0;
    bit d_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rdata(input logic [31:0] addr);
        if (addr == 32'h10) return 32'h0050_0093;
        return addr ^ 32'h1357_9BDF;
    endfunction

    task automatic expect_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we,
                              input bit is_data, input logic [31:0] data);
        req_t  r;
        resp_t p;
        r.addr = addr; r.wdata = wdata; r.we = we;
        p.is_data = is_data; p.data = data;
        exp_req.push_back(r);
        exp_resp.push_back(p);
    endtask

    task automatic send_data(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
        req_t r;
        r.addr = addr; r.wdata = wdata; r.we = we;
        d_q.push_back(r);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_resp.size() > 0 || exp_req.size() > 0 || if_q.size() > 0 || d_q.size() > 0 ||
                if_req_valid || d_req_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d responses outstanding, required 0", name, exp_resp.size());
            exp_resp.delete(); exp_req.delete(); if_q.delete(); d_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_mem_req_valid"}, 32'(mem_req_valid), 32'h0);
        check({name, "_mem_req_addr"}, mem_req_addr, 32'h0);
        check({name, "_mem_req_we"}, 32'(mem_req_write_en), 32'h0);
        check({name, "_if_resp_valid"}, 32'(if_resp_valid), 32'h0);
        check({name, "_if_resp_data"}, if_resp_data, 32'h0);
        check({name, "_d_resp_valid"}, 32'(d_resp_valid), 32'h0);
        check({name, "_d_resp_data"}, d_resp_data, 32'h0);
    endtask

    always @(negedge clk) begin
        if_acc = if_req_valid && if_req_ready;
        d_acc  = d_req_valid && d_req_ready;
    end

    // Fetch requester: holds valid until accepted, reloads immediately from its queue
    initial begin
        if_req_valid = 1'b0;
        if_req_addr  = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (if_acc) if_req_valid = 1'b0;
            if (!if_req_valid && if_q.size() > 0) begin
                if_req_addr  = if_q.pop_front();
                if_req_valid = 1'b1;
            end
        end
    end

    initial begin
        req_t r;
        d_req_valid    = 1'b0;
        d_req_addr     = 32'h0;
        d_req_wdata    = 32'h0;
        d_req_write_en = 4'h0;
        forever begin
            @(posedge clk); #1;
            if (d_acc) d_req_valid = 1'b0;
            if (!d_req_valid && d_q.size() > 0) begin
                r = d_q.pop_front();
                d_req_addr     = r.addr;
                d_req_wdata    = r.wdata;
                d_req_write_en = r.we;
                d_req_valid    = 1'b1;
            end
        end
    end

    // Memory responder: checks issued request, applies backpressure, returns one response
    initial begin
        req_t r;
        req_t cap;
        bit   stable_ok;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (auto_mem && mem_req_valid) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h, required no request", mem_req_addr);
                end else begin
                    r = exp_req.pop_front();
                    check("req_addr", mem_req_addr, r.addr);
                    check("req_wdata", mem_req_wdata, r.wdata);
                    check("req_we", 32'(mem_req_write_en), 32'(r.we));
                end
                cap.addr = mem_req_addr; cap.wdata = mem_req_wdata; cap.we = mem_req_write_en;
                stable_ok = 1'b1;
                for (int i = 0; i < ready_delay; i++) begin
                    if (stray && i == 1) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = 32'hBAD0_BAD0;
                    end
                    @(negedge clk);
                    mem_resp_valid = 1'b0;
                    if (!mem_req_valid || mem_req_addr !== cap.addr || mem_req_wdata !== cap.wdata ||
                        mem_req_write_en !== cap.we)
                        stable_ok = 1'b0;
                end
                if (ready_delay > 0) check("bp_stable", 32'(stable_ok), 32'h1);
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_rdata(cap.addr);
                @(negedge clk);
                mem_resp_valid = 1'b0;
            end
        end
    end

    // Response monitor and grant exclusivity
    always @(negedge clk) begin
        resp_t p;
        if (if_resp_valid || d_resp_valid) begin
            if (if_resp_valid && d_resp_valid) begin
                checks++;
                errors++;
                $display("FAIL resp_both: got if and d resp_valid together, required one");
            end else if (exp_resp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got if=%0b d=%0b, required none", if_resp_valid, d_resp_valid);
            end else begin
                p = exp_resp.pop_front();
                check("resp_owner_data", 32'(d_resp_valid), 32'(p.is_data));
                check("resp_data", d_resp_valid ? d_resp_data : if_resp_data, p.data);
            end
        end
        if (if_req_valid && d_req_valid && (if_req_ready || d_req_ready))
            check("ready_exclusive", 32'(if_req_ready && d_req_ready), 32'h0);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        check("reset_if_ready", 32'(if_req_ready), 32'h0);
        check("reset_d_ready", 32'(d_req_ready), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        expect_txn(32'h10, 32'h0, 4'h0, 1'b0, 32'h0050_0093);
        if_q.push_back(32'h10);
        wait_done("single_fetch");

        expect_txn(32'h40, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0);
        send_data(32'h40, 32'hDEAD_BEEF, 4'hF);
        wait_done("store");

        expect_txn(32'h44, 32'h0000_00AB, 4'h1, 1'b1, 32'h0);
        send_data(32'h44, 32'h0000_00AB, 4'h1);
        expect_txn(32'h80, 32'h0, 4'h0, 1'b1, 32'h1357_9B5F);
        send_data(32'h80, 32'h0, 4'h0);
        wait_done("byte_store_then_load");

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        expect_txn(32'h80, 32'h0, 4'h0, 1'b1, 32'h1357_9B5F);
        expect_txn(32'h14, 32'h0, 4'h0, 1'b0, 32'h1357_9BCB);
        expect_txn(32'h84, 32'h0, 4'h0, 1'b1, 32'h1357_9B5B);
        expect_txn(32'h18, 32'h0, 4'h0, 1'b0, 32'h1357_9BC7);
`else
        expect_txn(32'h80, 32'h0, 4'h0, 1'b1, 32'h1357_9B5F);
        expect_txn(32'h84, 32'h0, 4'h0, 1'b1, 32'h1357_9B5B);
        expect_txn(32'h14, 32'h0, 4'h0, 1'b0, 32'h1357_9BCB);
        expect_txn(32'h18, 32'h0, 4'h0, 1'b0, 32'h1357_9BC7);
`endif
        send_data(32'h80, 32'h0, 4'h0);
        send_data(32'h84, 32'h0, 4'h0);
        if_q.push_back(32'h14);
        if_q.push_back(32'h18);
        wait_done("conflict");

        ready_delay = 5;
        stray = 1'b1;
        expect_txn(32'h1C, 32'h0, 4'h0, 1'b0, 32'h1357_9BC3);
        if_q.push_back(32'h1C);
        wait_done("backpressure");
        ready_delay = 0;
        stray = 1'b0;

        auto_mem = 1'b0;
        if_q.push_back(32'h30);
        begin
            int n;
            n = 0;
            while (!mem_req_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_wait_issue", 32'(mem_req_valid), 32'h1);
        check("rst_wait_addr", mem_req_addr, 32'h30);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_cleared("rst_wait");
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1234_5678;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("late_resp_if", 32'(if_resp_valid), 32'h0);
        check("late_resp_mem_valid", 32'(mem_req_valid), 32'h0);
        repeat (2) @(negedge clk);
        auto_mem = 1'b1;

        expect_txn(32'h14, 32'h0, 4'h0, 1'b0, 32'h1357_9BCB);
        if_q.push_back(32'h14);
        wait_done("fetch_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
